controlador_botoes: RTL and testbench

CONTROLADOR_BOTOES -- requirements
Module: controlador_botoes

---
 rtl/controlador_botoes_pkg.sv | 16 +
 rtl/canal_botao.sv | 128 ++++++++++++
 rtl/controlador_botoes.sv | 46 ++++
 tb/tb_controlador_botoes.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_botoes_pkg.sv
// Shared types and default parameter values for the button controller.
package controlador_botoes_pkg;

    typedef enum logic [1:0] {
        SOLTO        = 2'd0,
        FILTRA_PRESS = 2'd1,
        PRESSIONADO  = 2'd2,
        FILTRA_SOLTA = 2'd3
    } estado_t;

    localparam int N_BOTOES_PADRAO = 4;
    localparam int DEBOUNCE_PADRAO = 16;
    localparam int LONG_PADRAO     = 1000;
    localparam int REPEAT_PADRAO   = 250;

endpackage

// File: rtl/canal_botao.sv
// One button channel: 2-flop synchronizer, debounce FSM, long-press and
// optional auto-repeat (macro CONTROLADOR_BOTOES_REPEAT_EN).
//
// state        | meaning
// SOLTO        | released, waiting for a low sample
// FILTRA_PRESS | low seen, counting stable low samples
// PRESSIONADO  | press confirmed, long/repeat timers running
// FILTRA_SOLTA | high seen while held, counting stable high samples
module canal_botao
    import controlador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
`ifdef CONTROLADOR_BOTOES_REPEAT_EN
    parameter int REPEAT_CICLOS   = REPEAT_PADRAO,
`endif
    parameter int LONG_CICLOS     = LONG_PADRAO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b_in,
    output logic b_out,
    output logic b_hold_out,
    output logic b_long_out
);

    localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int LW = $clog2(LONG_CICLOS + 1);
    localparam logic [DW-1:0] DEB_FIM    = DW'(DEBOUNCE_CICLOS - 1);
    localparam logic [LW-1:0] LONG_FIM   = LW'(LONG_CICLOS);
    localparam logic [LW-1:0] LONG_PENULT = LW'(LONG_CICLOS - 1);

    logic          s1, s;
    estado_t       estado, prox_estado;
    logic [DW-1:0] deb_cnt, deb_prox;
    logic [LW-1:0] long_cnt, long_prox;
    logic          pulso, longo;

`ifdef CONTROLADOR_BOTOES_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CICLOS + 1);
    localparam logic [RW-1:0] REP_FIM = RW'(REPEAT_CICLOS - 1);
    logic [RW-1:0] rep_cnt, rep_prox;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b1;
            s          <= 1'b1;
            estado     <= SOLTO;
            deb_cnt    <= '0;
            long_cnt   <= '0;
            b_out      <= 1'b0;
            b_long_out <= 1'b0;
`ifdef CONTROLADOR_BOTOES_REPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            s1         <= b_in;
            s          <= s1;
            estado     <= prox_estado;
            deb_cnt    <= deb_prox;
            long_cnt   <= long_prox;
            b_out      <= pulso;
            b_long_out <= longo;
`ifdef CONTROLADOR_BOTOES_REPEAT_EN
            rep_cnt    <= rep_prox;
`endif
        end
    end

    // A single contrary sample in either filter state discards the progress.
    always_comb begin
        prox_estado = estado;
        deb_prox    = deb_cnt;
        case (estado)
            SOLTO: begin
                if (!s) begin
                    prox_estado = FILTRA_PRESS;
                    deb_prox    = '0;
                end
            end
            FILTRA_PRESS: begin
                if (s)                       prox_estado = SOLTO;
                else if (deb_cnt == DEB_FIM) prox_estado = PRESSIONADO;
                else                         deb_prox    = deb_cnt + 1'b1;
            end
            PRESSIONADO: begin
                if (s) begin
                    prox_estado = FILTRA_SOLTA;
                    deb_prox    = '0;
                end
            end
            FILTRA_SOLTA: begin
                if (!s)                      prox_estado = PRESSIONADO;
                else if (deb_cnt == DEB_FIM) prox_estado = SOLTO;
                else                         deb_prox    = deb_cnt + 1'b1;
            end
            default: prox_estado = SOLTO;
        endcase
    end

    always_comb begin
        pulso      = (estado == FILTRA_PRESS) && (prox_estado == PRESSIONADO);
        longo      = 1'b0;
        long_prox  = long_cnt;
        b_hold_out = (estado == PRESSIONADO) || (estado == FILTRA_SOLTA);
        if (estado == SOLTO) begin
            long_prox = '0;
        end else if (estado == PRESSIONADO && long_cnt != LONG_FIM) begin
            long_prox = long_cnt + 1'b1;
            longo     = (long_cnt == LONG_PENULT);
        end
`ifdef CONTROLADOR_BOTOES_REPEAT_EN
        // Repeat timer only runs once the long counter has saturated.
        rep_prox = rep_cnt;
        if (estado == SOLTO) begin
            rep_prox = '0;
        end else if (estado == PRESSIONADO && long_cnt == LONG_FIM) begin
            if (rep_cnt == REP_FIM) begin
                rep_prox = '0;
                pulso    = 1'b1;
            end else begin
                rep_prox = rep_cnt + 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/controlador_botoes.sv
// Multi-channel debounced button controller; one canal_botao per input bit.
// Auto-repeat is enabled by defining CONTROLADOR_BOTOES_REPEAT_EN.
module controlador_botoes
    import controlador_botoes_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter int LONG_CICLOS     = LONG_PADRAO,
    parameter int REPEAT_CICLOS   = REPEAT_PADRAO
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_BOTOES-1:0] b_in,
    output logic [N_BOTOES-1:0] b_out,
    output logic [N_BOTOES-1:0] b_hold_out,
    output logic [N_BOTOES-1:0] b_long_out
);

    localparam bit PARAMS_OK = (N_BOTOES >= 1) && (DEBOUNCE_CICLOS >= 1) &&
                               (LONG_CICLOS > DEBOUNCE_CICLOS) && (REPEAT_CICLOS >= 1);

    // An illegal parameter set leaves the block inert rather than half-working.
    if (PARAMS_OK) begin : g_canais
        for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
            canal_botao #(
                .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
`ifdef CONTROLADOR_BOTOES_REPEAT_EN
                .REPEAT_CICLOS  (REPEAT_CICLOS),
`endif
                .LONG_CICLOS    (LONG_CICLOS)
            ) u_canal (
                .clk       (clk),
                .rst_n     (rst_n),
                .b_in      (b_in[i]),
                .b_out     (b_out[i]),
                .b_hold_out(b_hold_out[i]),
                .b_long_out(b_long_out[i])
            );
        end
    end else begin : g_invalido
        assign b_out      = '0;
        assign b_hold_out = '0;
        assign b_long_out = '0;
    end

endmodule

// File: tb/tb_controlador_botoes.sv
// Self-checking bench for controlador_botoes: directed scenarios plus random
// bouncing, compared cycle by cycle against a run-length behavioural model.
module tb_controlador_botoes;

    localparam int N = 4;
    localparam int D = 16;
    localparam int L = 100;
    localparam int R = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] b_in;
    logic [N-1:0] b_out, b_hold_out, b_long_out;

    controlador_botoes #(
        .N_BOTOES(N), .DEBOUNCE_CICLOS(D), .LONG_CICLOS(L), .REPEAT_CICLOS(R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .b_in(b_in),
        .b_out(b_out), .b_hold_out(b_hold_out), .b_long_out(b_long_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a press is confirmed after D+1 consecutive low synchronized
    // samples, a release after D+1 consecutive high ones.
    bit           pressed [N];
    int           zero_run[N];
    int           one_run [N];
    int           held    [N];
    logic [N-1:0] sm, s1m;
    logic [N-1:0] exp_out, exp_hold, exp_long;
    int           pulsos[$];

    task automatic check_bits(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            pressed[ch]  = 1'b0;
            zero_run[ch] = 0;
            one_run[ch]  = 0;
            held[ch]     = 0;
        end
        sm       = '1;
        s1m      = '1;
        exp_out  = '0;
        exp_hold = '0;
        exp_long = '0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < N; ch++) begin
            logic s;
            s = sm[ch];
            exp_out[ch]  = 1'b0;
            exp_long[ch] = 1'b0;
            if (!pressed[ch]) begin
                zero_run[ch] = s ? 0 : zero_run[ch] + 1;
                if (zero_run[ch] == D + 1) begin
                    pressed[ch]  = 1'b1;
                    zero_run[ch] = 0;
                    one_run[ch]  = 0;
                    held[ch]     = 0;
                    exp_out[ch]  = 1'b1;
                end
            end else begin
                if (one_run[ch] == 0) begin
                    held[ch]++;
                    if (held[ch] == L) exp_long[ch] = 1'b1;
`ifdef CONTROLADOR_BOTOES_REPEAT_EN
                    if (held[ch] > L && (held[ch] - L) % R == 0) exp_out[ch] = 1'b1;
`endif
                end
                one_run[ch] = s ? one_run[ch] + 1 : 0;
                if (one_run[ch] == D + 1) begin
                    pressed[ch]  = 1'b0;
                    one_run[ch]  = 0;
                    zero_run[ch] = 0;
                    held[ch]     = 0;
                end
            end
            exp_hold[ch] = pressed[ch];
        end
        sm  = s1m;
        s1m = b_in;
    endtask

    task automatic step(input logic [N-1:0] v);
        b_in = v;
        @(posedge clk);
        model_edge();
        #1;
        check_bits("b_out", b_out, exp_out);
        check_bits("b_hold_out", b_hold_out, exp_hold);
        check_bits("b_long_out", b_long_out, exp_long);
    endtask

    // Edges are numbered from 1, starting at the first edge after b_in changed.
    task automatic run_edges(input int n, input int ch, output int first, output int count,
                             output int long_first, output int long_count);
        first = -1; count = 0; long_first = -1; long_count = 0;
        pulsos.delete();
        for (int k = 1; k <= n; k++) begin
            step(b_in);
            if (b_out[ch]) begin
                if (first < 0) first = k;
                count++;
                pulsos.push_back(k);
            end
            if (b_long_out[ch]) begin
                if (long_first < 0) long_first = k;
                long_count++;
            end
        end
    endtask

    task automatic soltar_tudo();
        int f, c, lf, lc;
        b_in = '1;
        run_edges(D + 8, 0, f, c, lf, lc);
    endtask

    initial begin
        int f, c, lf, lc;
        int n_seg, len, mode;
        logic [N-1:0] v;

        rst_n = 1'b0;
        b_in  = '1;
        model_reset();
        #2;
        check_bits("reset_b_out", b_out, '0);
        check_bits("reset_b_hold", b_hold_out, '0);
        check_bits("reset_b_long", b_long_out, '0);
        for (int k = 0; k < 3; k++) step('1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step('1);

        // Clean press on channel 0
        b_in = 4'b1110;
        run_edges(25, 0, f, c, lf, lc);
        check_int("clean_press_edge", f, D + 3);
        check_int("clean_press_count", c, 1);
        soltar_tudo();

        // Bounce on channel 1: low 10, high 1, low 20
        b_in = 4'b1101;
        run_edges(10, 1, f, c, lf, lc);
        check_int("bounce_early_count", c, 0);
        b_in = 4'b1111;
        run_edges(1, 1, f, c, lf, lc);
        check_int("bounce_glitch_count", c, 0);
        b_in = 4'b1101;
        run_edges(20, 1, f, c, lf, lc);
        check_int("bounce_edge", f, D + 3);
        check_int("bounce_count", c, 1);
        soltar_tudo();

        // Long press on channel 0
        b_in = 4'b1110;
`ifdef CONTROLADOR_BOTOES_REPEAT_EN
        run_edges(D + 3 + L + 200, 0, f, c, lf, lc);
        check_int("long_press_edge", f, D + 3);
        check_int("long_pulse_edge", lf, D + 3 + L);
        check_int("long_pulse_count", lc, 1);
        check_int("repeat_count", c, 11);
        if (pulsos.size() == 11) begin
            check_int("repeat_first", pulsos[1], D + 3 + L + R);
            for (int i = 2; i <= 10; i++) check_int("repeat_spacing", pulsos[i] - pulsos[i-1], R);
        end
`else
        run_edges(D + 3 + 150, 0, f, c, lf, lc);
        check_int("long_press_edge", f, D + 3);
        check_int("long_pulse_edge", lf, D + 3 + L);
        check_int("long_pulse_count", lc, 1);
        check_int("long_no_repeat", c, 1);
`endif
        soltar_tudo();

        // Reset in the middle of a hold on channel 2
        b_in = 4'b1011;
        run_edges(30, 2, f, c, lf, lc);
        check_int("pre_reset_count", c, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_bits("midreset_b_out", b_out, '0);
        check_bits("midreset_b_hold", b_hold_out, '0);
        check_bits("midreset_b_long", b_long_out, '0);
        for (int k = 0; k < 3; k++) step(b_in);
        rst_n = 1'b1;
        run_edges(25, 2, f, c, lf, lc);
        check_int("post_reset_edge", f, D + 3);
        check_int("post_reset_count", c, 1);
        soltar_tudo();

        // Simultaneous press on channels 0 and 3
        for (int k = 1; k < D + 3; k++) step(4'b0110);
        check_bits("simul_before", b_out, '0);
        step(4'b0110);
        check_bits("simul_pulse", b_out, 4'b1001);
        soltar_tudo();

        // Random segments: steady, heavy bounce, light bounce
        n_seg = 30;
        for (int seg = 0; seg < n_seg; seg++) begin
            mode = $urandom_range(0, 2);
            len  = $urandom_range(20, 150);
            v    = N'($urandom);
            for (int k = 0; k < len; k++) begin
                for (int ch = 0; ch < N; ch++) begin
                    if (mode == 1 && $urandom_range(0, 7) == 0)  v[ch] = ~v[ch];
                    if (mode == 2 && $urandom_range(0, 29) == 0) v[ch] = ~v[ch];
                end
                step(v);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
